photon_deadlock_report_ctrl: RTL and testbench

Collects the `block` and `axis_block_info` outputs of up to N per-instance HLS deadlock monitors in the photon pipeline. It filters out transient stalls with a persistence counter and latches qualified events. Pending reports are arbitrated round-robin and serialised onto a single valid/ready report stream for the control/status interface, alongside per-monitor sticky flags.

---
 rtl/photon_deadlock_report_ctrl.sv | 142 ++++++++++++++
 tb/tb_photon_deadlock_report_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/photon_deadlock_report_ctrl.sv
// photon_deadlock_report_ctrl: qualifies persistent HLS deadlock stalls
// and serialises them round-robin onto one valid/ready report stream.
module photon_deadlock_report_ctrl #(
    parameter int N_MON   = 4,
    parameter int INFO_W  = 9,
    parameter int PERSIST = 16,
    parameter int TS_W    = 32,
    localparam int IDX_W  = $clog2(N_MON)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_MON-1:0]        mon_block,
    input  logic [N_MON*INFO_W-1:0] mon_info,
    input  logic [N_MON-1:0]        clear_sticky,
    output logic                    rpt_valid,
    input  logic                    rpt_ready,
    output logic [IDX_W-1:0]        rpt_idx,
    output logic [INFO_W-1:0]       rpt_info,
    output logic [TS_W-1:0]         rpt_ts,
    output logic [N_MON-1:0]        sticky,
    output logic [N_MON-1:0]        pending,
    output logic                    overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    localparam logic [15:0] P_MAX = 16'(PERSIST);
    localparam logic [15:0] P_QUA = 16'(PERSIST - 1);

    state_t             state_q;
    state_t             state_d;
    logic [TS_W-1:0]    ts_q;
    logic [15:0]        run_q   [N_MON];
    logic [INFO_W-1:0]  info_q  [N_MON];
    logic [TS_W-1:0]    tsl_q   [N_MON];
    logic [N_MON-1:0]   armed_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   pick;
    logic               found;
    logic               accept;
    logic [N_MON-1:0]   qual;
    logic [N_MON-1:0]   acc_mask;
    logic [N_MON-1:0]   relatch;
    logic               lost;

    // Round-robin search starting just after the last granted monitor
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_MON; k++) begin
            if (!found && pending[(int'(last_q) + k) % N_MON]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(last_q) + k) % N_MON);
            end
        end
    end

    // Qualification; a requalify on the accept edge re-latches cleanly
    always_comb begin
        acc_mask = '0;
        if (accept) acc_mask[rpt_idx] = 1'b1;
        for (int i = 0; i < N_MON; i++) begin
            qual[i] = enable && mon_block[i] && armed_q[i]
                      && (run_q[i] == P_QUA);
        end
        relatch = qual & (~pending | acc_mask);
        lost    = |(qual & pending & ~acc_mask);
    end

    // Report FSM next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        rpt_valid = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            S_IDLE: if (found) state_d = S_SEND;
            S_SEND: begin
                rpt_valid = 1'b1;
                accept    = rpt_ready;
                if (rpt_ready) state_d = S_GAP;
            end
            S_GAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Counters, latches, flags and report registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            ts_q     <= '0;
            armed_q  <= '1;
            last_q   <= IDX_W'(N_MON - 1);
            pending  <= '0;
            sticky   <= '0;
            overflow <= 1'b0;
            rpt_idx  <= '0;
            rpt_info <= '0;
            rpt_ts   <= '0;
            for (int i = 0; i < N_MON; i++) begin
                run_q[i]  <= '0;
                info_q[i] <= '0;
                tsl_q[i]  <= '0;
            end
        end else begin
            ts_q <= ts_q + 1'b1;
            for (int i = 0; i < N_MON; i++) begin
                if (enable && mon_block[i])
                    run_q[i] <= (run_q[i] == P_MAX) ? P_MAX
                                                   : run_q[i] + 16'd1;
                else
                    run_q[i] <= '0;
                if (!mon_block[i]) armed_q[i] <= 1'b1;
                else if (qual[i])  armed_q[i] <= 1'b0;
                if (relatch[i]) begin
                    info_q[i] <= mon_info[i*INFO_W +: INFO_W];
                    tsl_q[i]  <= ts_q;
                end
            end
            pending <= (pending & ~acc_mask) | qual;
            sticky  <= (sticky & ~clear_sticky) | qual;
            if (lost) overflow <= 1'b1;
            if (state_q == S_IDLE && found) begin
                rpt_idx  <= pick;
                rpt_info <= info_q[pick];
                rpt_ts   <= tsl_q[pick];
            end
            if (accept) last_q <= rpt_idx;
        end
    end

endmodule

// File: tb/tb_photon_deadlock_report_ctrl.sv
// tb_photon_deadlock_report_ctrl: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural report model.
module tb_photon_deadlock_report_ctrl;

    localparam int N  = 4;
    localparam int IW = 9;
    localparam int P  = 16;
    localparam int TW = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic          ready = 1'b0;
    logic [N-1:0]  blk   = '0;
    logic [N-1:0]  clr   = '0;
    logic [N*IW-1:0] info = '0;

    logic          rpt_valid;
    logic [1:0]    rpt_idx;
    logic [IW-1:0] rpt_info;
    logic [TW-1:0] rpt_ts;
    logic [N-1:0]  sticky;
    logic [N-1:0]  pending;
    logic          overflow;

    photon_deadlock_report_ctrl #(
        .N_MON(N), .INFO_W(IW), .PERSIST(P), .TS_W(TW)
    ) dut (
        .clock        (clk),
        .reset        (rst_n),
        .enable       (en),
        .mon_block    (blk),
        .mon_info     (info),
        .clear_sticky (clr),
        .rpt_valid    (rpt_valid),
        .rpt_ready    (ready),
        .rpt_idx      (rpt_idx),
        .rpt_info     (rpt_info),
        .rpt_ts       (rpt_ts),
        .sticky       (sticky),
        .pending      (pending),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int acc_q[$];
    int acc_t[$];

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: stall episodes, report slot with cooldown
    int          m_run [N];
    bit          m_arm [N];
    bit          m_pnd [N];
    bit          m_stk [N];
    int          m_inf [N];
    logic [TW-1:0] m_tsl [N];
    logic [TW-1:0] m_ts;
    bit          m_ovf;
    bit          m_val;
    bit          m_cool;
    int          m_idx;
    int          m_rinf;
    logic [TW-1:0] m_rts;
    int          m_last;

    always @(posedge clk) begin : model
        bit got;
        bit b;
        cyc++;
        if (rst_n && m_val && ready) begin
            acc_q.push_back(m_idx);
            acc_t.push_back(cyc);
        end
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0; m_arm[i] = 1; m_pnd[i] = 0;
                m_stk[i] = 0; m_inf[i] = 0; m_tsl[i] = '0;
            end
            m_ts = '0; m_ovf = 0; m_val = 0; m_cool = 0;
            m_idx = 0; m_rinf = 0; m_rts = '0; m_last = N - 1;
        end else begin
            if (m_val) begin
                if (ready) begin
                    m_val = 0; m_cool = 1; m_last = m_idx;
                    m_pnd[m_idx] = 0;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else begin
                got = 0;
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (!got && m_pnd[j]) begin
                        got = 1; m_val = 1; m_idx = j;
                        m_rinf = m_inf[j]; m_rts = m_tsl[j];
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                b = blk[i] && en;
                if (clr[i]) m_stk[i] = 0;
                if (b && m_run[i] == P - 1 && m_arm[i]) begin
                    m_stk[i] = 1;
                    m_arm[i] = 0;
                    if (m_pnd[i]) m_ovf = 1;
                    else begin
                        m_pnd[i] = 1;
                        m_inf[i] = int'(info[i*IW +: IW]);
                        m_tsl[i] = m_ts;
                    end
                end
                m_run[i] = b ? ((m_run[i] >= P) ? P : m_run[i] + 1) : 0;
                if (!blk[i]) m_arm[i] = 1;
            end
            m_ts = m_ts + 1;
        end
    end

    task automatic check_all();
        logic [N-1:0] ep;
        logic [N-1:0] es;
        for (int i = 0; i < N; i++) begin
            ep[i] = m_pnd[i];
            es[i] = m_stk[i];
        end
        chk("rpt_valid", 64'(rpt_valid), 64'(m_val));
        chk("rpt_idx",   64'(rpt_idx),   64'(m_idx));
        chk("rpt_info",  64'(rpt_info),  64'(m_rinf));
        chk("rpt_ts",    64'(rpt_ts),    64'(m_rts));
        chk("pending",   64'(pending),   64'(ep));
        chk("sticky",    64'(sticky),    64'(es));
        chk("overflow",  64'(overflow),  64'(m_ovf));
    endtask

    task automatic step(input logic r, input logic e, input logic rd,
                        input logic [N-1:0] b, input logic [N-1:0] c,
                        input int n);
        for (int k = 0; k < n; k++) begin
            rst_n = r; en = e; ready = rd; blk = b; clr = c;
            info  = (N*IW)'({$urandom(), $urandom()});
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic rand_run(input int n);
        logic [N-1:0] b;
        b = '0;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(11) == 0) b[i] = ~b[i];
            rst_n = ($urandom_range(499) != 0);
            en    = ($urandom_range(29) != 0);
            ready = ($urandom_range(3) != 0);
            blk   = b;
            for (int i = 0; i < N; i++)
                clr[i] = ($urandom_range(15) == 0);
            info  = (N*IW)'({$urandom(), $urandom()});
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        step(0, 1, 1, 4'b0000, 4'b0000, 3);
        chk("reset_valid", 64'(rpt_valid), 64'd0);

        // single monitor 2 stall, one report
        acc_q.delete(); acc_t.delete();
        step(1, 1, 1, 4'b0100, 4'b0000, 20);
        step(1, 1, 1, 4'b0000, 4'b0000, 10);
        chk("tp1_count", 64'(acc_q.size()), 64'd1);
        if (acc_q.size() > 0) chk("tp1_idx", 64'(acc_q[0]), 64'd2);
        chk("tp1_sticky", 64'(sticky), 64'b0100);

        // dropout one short of qualification
        step(1, 1, 1, 4'b0000, 4'b1111, 1);
        step(1, 1, 1, 4'b0010, 4'b0000, 15);
        step(1, 1, 1, 4'b0000, 4'b0000, 1);
        step(1, 1, 1, 4'b0010, 4'b0000, 15);
        step(1, 1, 1, 4'b0000, 4'b0000, 5);
        chk("tp2_sticky", 64'(sticky), 64'd0);

        // simultaneous qualification, then 3 and 1
        step(0, 1, 1, 4'b0000, 4'b0000, 2);
        acc_q.delete(); acc_t.delete();
        step(1, 1, 1, 4'b1111, 4'b0000, 20);
        step(1, 1, 1, 4'b0000, 4'b0000, 10);
        step(1, 1, 1, 4'b1010, 4'b0000, 20);
        step(1, 1, 1, 4'b0000, 4'b0000, 10);
        chk("tp3_count", 64'(acc_q.size()), 64'd6);
        if (acc_q.size() == 6) begin
            int exp_o[6] = '{0, 1, 2, 3, 1, 3};
            for (int k = 0; k < 6; k++)
                chk("tp3_order", 64'(acc_q[k]), 64'(exp_o[k]));
            for (int k = 0; k < 3; k++)
                chk("tp3_gap", 64'(acc_t[k+1] - acc_t[k]), 64'd3);
        end

        // stalled consumer with a requalification of monitor 0
        step(0, 1, 1, 4'b0000, 4'b0000, 2);
        acc_q.delete();
        step(1, 1, 0, 4'b0001, 4'b0000, 20);
        step(1, 1, 0, 4'b0000, 4'b0000, 3);
        step(1, 1, 0, 4'b0001, 4'b0000, 27);
        chk("tp4_ovf", 64'(overflow), 64'd1);
        step(1, 1, 1, 4'b0000, 4'b0000, 10);
        chk("tp4_count", 64'(acc_q.size()), 64'd1);

        // clear and set on the same edge: set wins
        step(1, 1, 1, 4'b0001, 4'b0000, 15);
        step(1, 1, 1, 4'b0001, 4'b0001, 1);
        chk("tp5_win", 64'(sticky[0]), 64'd1);
        step(1, 1, 1, 4'b0001, 4'b0000, 5);
        step(1, 1, 1, 4'b0001, 4'b0001, 1);
        chk("tp5_clr", 64'(sticky[0]), 64'd0);
        step(1, 1, 1, 4'b0000, 4'b0000, 5);

        // reset during SEND
        step(1, 1, 0, 4'b1000, 4'b0000, 17);
        chk("tp6_send", 64'(rpt_valid), 64'd1);
        step(0, 1, 0, 4'b0000, 4'b0000, 1);
        chk("tp6_valid", 64'(rpt_valid), 64'd0);
        chk("tp6_ovf", 64'({pending, sticky, overflow}), 64'd0);
        acc_q.delete();
        step(1, 1, 1, 4'b1011, 4'b0000, 20);
        if (acc_q.size() > 0) chk("tp6_first", 64'(acc_q[0]), 64'd0);
        else chk("tp6_first", 64'd99, 64'd0);
        step(1, 1, 1, 4'b0000, 4'b0000, 10);

        rand_run(4000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
